// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register with valid/ready handshake, synchronous flush and an
// optional 2-entry skid buffer. Invalid slots present the BUBBLE payload downstream.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH  = 64,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
    parameter int unsigned      SKID   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             main_free;
    logic             in_xfer;

    assign main_free = ~main_valid_q | out_ready;

    // With the skid entry, in_ready depends only on held state (plus flush).
    always_comb begin
        if (SKID != 0) begin
            in_ready = ~skid_valid_q & ~flush;
        end else begin
            in_ready = main_free & ~flush;
        end
    end

    assign in_xfer = in_valid & in_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            main_valid_d = 1'b0;
            main_data_d  = BUBBLE;
            skid_valid_d = 1'b0;
            skid_data_d  = BUBBLE;
        end else if (SKID == 0) begin
            if (in_ready) begin
                main_valid_d = in_xfer;
                main_data_d  = in_xfer ? in_data : BUBBLE;
            end
        end else if (main_free) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = in_xfer;
                skid_data_d  = in_xfer ? in_data : BUBBLE;
            end else begin
                main_valid_d = in_xfer;
                main_data_d  = in_xfer ? in_data : BUBBLE;
            end
        end else if (in_xfer) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_valid_q <= 1'b0;
            main_data_q  <= BUBBLE;
            skid_valid_q <= 1'b0;
            skid_data_q  <= BUBBLE;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign out_valid = main_valid_q;
    assign out_data  = main_valid_q ? main_data_q : BUBBLE;
    assign occupancy = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: SKID=1 and SKID=0 instances share one stimulus stream,
// each checked by its own queue-based scoreboard plus directed checks.
module tb_pipe_stage_reg;

    localparam logic [63:0] BUBBLE = 64'h0000_0000_0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_data;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned SK = (g == 0) ? 1 : 0;
        logic        in_ready;
        logic        out_valid;
        logic [63:0] out_data;
        logic [1:0]  occupancy;
        logic [63:0] q[$];

        pipe_stage_reg #(
            .WIDTH (64),
            .BUBBLE(BUBBLE),
            .SKID  (SK)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .in_data  (in_data),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .out_data (out_data),
            .occupancy(occupancy)
        );

        // Monitor: sample mid-cycle, decide what the coming edge transfers.
        always @(negedge clk) begin
            logic exp_rdy;
            if (rst) begin
                q.delete();
            end else begin
                chk($sformatf("d%0d occupancy", g), 64'(occupancy), 64'(q.size()));
                chk($sformatf("d%0d out_valid", g), 64'(out_valid), 64'(q.size() != 0));
                if (!out_valid) chk($sformatf("d%0d bubble", g), out_data, BUBBLE);
                if (flush) exp_rdy = 1'b0;
                else if (SK != 0) exp_rdy = (q.size() < 2);
                else exp_rdy = (q.size() == 0) || out_ready;
                chk($sformatf("d%0d in_ready", g), 64'(in_ready), 64'(exp_rdy));
                if (out_valid && out_ready && q.size() > 0)
                    chk($sformatf("d%0d out_data", g), out_data, q.pop_front());
                if (flush) q.delete();
                else if (in_valid && in_ready) q.push_back(in_data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer d until the SKID=1 instance accepts it; in_valid stays high afterwards.
    task automatic push(input logic [63:0] d);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = g_dut[0].in_ready;
            step();
        end
        if (!ok) chk("push timeout", 64'd0, 64'd1);
    endtask

    localparam logic [63:0] A = 64'hAAAA_0000_0000_000A;
    localparam logic [63:0] B = 64'hBBBB_0000_0000_000B;
    localparam logic [63:0] C = 64'hCCCC_0000_0000_000C;
    localparam logic [63:0] D = 64'hDDDD_0000_0000_000D;
    localparam logic [63:0] E = 64'hEEEE_0000_0000_000E;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);
        chk("reset out_valid", 64'(g_dut[0].out_valid), 64'd0);
        chk("reset out_data", g_dut[0].out_data, BUBBLE);
        chk("reset occupancy", 64'(g_dut[0].occupancy), 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset in_ready", 64'(g_dut[0].in_ready), 64'd1);
        step();

        // Streaming, no stalls
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = {32'(4 * (i + 1)), 16'(16'h2002 + i), 16'(16'h0001 + i)};
            step();
        end
        in_valid = 1'b0;
        repeat (3) step();

        // Stall fills main then skid; C waits upstream
        out_ready = 1'b0;
        push(A);
        push(B);
        in_data = C;
        @(negedge clk);
        chk("stall d1 in_ready", 64'(g_dut[0].in_ready), 64'd0);
        chk("stall d1 occupancy", 64'(g_dut[0].occupancy), 64'd2);
        chk("stall d1 out_data", g_dut[0].out_data, A);
        chk("stall d0 in_ready", 64'(g_dut[1].in_ready), 64'd0);
        chk("stall d0 out_data", g_dut[1].out_data, A);
        step();
        out_ready = 1'b1;
        @(negedge clk);
        chk("bypass d0 in_ready", 64'(g_dut[1].in_ready), 64'd1);
        step();
        @(negedge clk);
        chk("bypass d0 out_data", g_dut[1].out_data, C);
        chk("release d1 out_data", g_dut[0].out_data, B);
        step();
        push(C);
        in_valid = 1'b0;
        repeat (3) step();

        // Flush with A in main, B in skid, D offered
        out_ready = 1'b0;
        push(A);
        push(B);
        in_data = D;
        flush   = 1'b1;
        @(negedge clk);
        chk("flush d1 in_ready", 64'(g_dut[0].in_ready), 64'd0);
        chk("flush d0 in_ready", 64'(g_dut[1].in_ready), 64'd0);
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            logic        v;
            logic [63:0] d;
            logic [1:0]  o;
            v = (i == 0) ? g_dut[0].out_valid : g_dut[1].out_valid;
            d = (i == 0) ? g_dut[0].out_data : g_dut[1].out_data;
            o = (i == 0) ? g_dut[0].occupancy : g_dut[1].occupancy;
            chk($sformatf("post-flush d%0d out_valid", i), 64'(v), 64'd0);
            chk($sformatf("post-flush d%0d out_data", i), d, BUBBLE);
            chk($sformatf("post-flush d%0d occupancy", i), 64'(o), 64'd0);
        end
        step();
        out_ready = 1'b1;
        push(E);
        in_valid = 1'b0;
        @(negedge clk);
        chk("post-flush d1 E", g_dut[0].out_data, E);
        chk("post-flush d0 E", g_dut[1].out_data, E);
        repeat (2) step();

        // Asynchronous reset mid-cycle with two entries held
        out_ready = 1'b0;
        push(A);
        push(B);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("async rst out_valid", 64'(g_dut[0].out_valid), 64'd0);
        chk("async rst out_data", g_dut[0].out_data, BUBBLE);
        chk("async rst occupancy", 64'(g_dut[0].occupancy), 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("release d1 in_ready", 64'(g_dut[0].in_ready), 64'd1);
        chk("release d0 in_ready", 64'(g_dut[1].in_ready), 64'd1);
        step();

        // Random soak
        for (int i = 0; i < 10000; i++) begin
            in_valid  = ($urandom_range(3) != 0);
            in_data   = {$urandom, $urandom};
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(39) == 0);
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register; generalises the fixed 64-bit IF/ID stall register to any payload width.
- Adds a valid/ready handshake, synchronous flush (bubble insertion) and an optional 2-entry skid buffer, so in_ready can be registered.
- Instantiated between any two CPU pipeline stages: IF/ID, ID/EX, EX/MEM, MEM/WB.
- Invalid slots present a configurable bubble payload (NOP) downstream.

Parameters:
- WIDTH, 64, payload width in bits (IF/ID: pcAdd4 + instruction).
- BUBBLE, {WIDTH{1'b0}}, payload driven on out_data whenever out_valid=0; also the reset/flush value.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register, combinational in_ready.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- flush  input  1  synchronous squash of all held entries (branch mispredict / exception)
- in_valid  input  1  upstream offers in_data
- in_ready  output  1  stage can accept this cycle
- in_data  input  WIDTH  upstream payload
- out_valid  output  1  out_data holds a real instruction
- out_ready  input  1  downstream consumes this cycle (0 = stall)
- out_data  output  WIDTH  payload to next stage
- occupancy  output  2  number of held entries: 0..2, or 0..1 when SKID=0

Behaviour:
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Reset (async, rst=1, any time, including mid-transfer):
  - main and skid entries invalid; stored data = BUBBLE.
  - out_valid=0, out_data=BUBBLE, occupancy=0.
  - in_ready=1 while rst is low after release.
- Storage: main entry (drives out_*) plus, when SKID=1, one skid entry.
- out_data = main_data when main_valid, else BUBBLE. Never expose stale data while out_valid=0.
- Latency: 1 cycle. A beat accepted at edge N appears on out_* after edge N; no combinational path from in_data to out_data.
- SKID=0:
  - in_ready = ~main_valid | out_ready (combinational).
  - Each edge:
    - If in_ready: main <= in beat (valid=in_valid).
    - Otherwise hold.
- SKID=1 (in_ready = ~skid_valid, a registered-state function only):
  - Each edge, main_free = ~main_valid | out_ready.
  - main_free & skid_valid: main <= skid; skid <= input transfer beat if any, else invalid.
  - main_free & ~skid_valid: main <= input beat (valid = input transfer).
  - ~main_free & input transfer: skid <= input beat; main holds.
  - ~main_free & no transfer: hold everything.
- Ordering: strictly FIFO; the skid entry is always older than any newly accepted beat.
- Flush (sync, sampled at edge):
  - Next state: all entries invalid, data = BUBBLE, occupancy=0.
  - in_ready is forced 0 while flush=1, so no input transfer occurs in a flush cycle.
  - An output transfer in the flush cycle still completes; the downstream beat presented that cycle is consumed normally.
  - flush dominates out_ready and in_valid.
- Stall (out_ready=0) holds out_data/out_valid stable. When SKID=1, it accepts at most one further beat, then deasserts in_ready.
- Simultaneous out_ready=1 & input transfer with occupancy=1 and SKID=1: main replaced by the new beat, occupancy stays 1, no skid use.
- occupancy = main_valid + skid_valid. Never exceeds 2; never decrements below 0.
- X-safety: in_data is ignored when in_valid=0; no entry becomes valid from an X payload without in_valid.

Test Plan:
- Reset: assert rst mid-stream with occupancy=2 -> out_valid=0, out_data=BUBBLE, occupancy=0 immediately (before next edge); in_ready=1 after release.
- Streaming (SKID=1, WIDTH=64): out_ready=1, push 0x0000_0004_2002_0001, 0x0000_0008_2003_0002, ... one per cycle -> identical sequence out, 1-cycle latency, occupancy=1, no bubbles.
- Stall/skid, SKID=1:
  - out_ready=0 while pushing A, B, C -> A in main, B in skid, in_ready=0 after B, C held upstream.
  - Release out_ready -> outputs A, B, C in order, no loss or duplication.
- Flush:
  - With A in main and B in skid, assert flush with in_valid=1 (D) -> next cycle out_valid=0, out_data=BUBBLE, occupancy=0, D not accepted (in_ready=0 during flush).
  - Then push E -> E out next cycle.
- SKID=0 bypass: out_ready=0 with A held -> in_ready=0 same cycle. Raise out_ready with in_valid=1 (B) -> in_ready=1 combinationally, B replaces A on the edge.
- Random soak: random in_valid/out_ready/flush over 10k cycles against a scoreboard -> FIFO order, no beat lost except by flush, out_data=BUBBLE whenever out_valid=0.
